idct2d_sequencer: RTL and testbench

//  Sequences one shared 8-point 1-D IDCT unit (rowidct: x0..x7 in, y0..y7 out, rdy) through a full 8x8 2-D IDCT.

---
 rtl/idct2d_sequencer.sv | 120 ++++++++++++
 tb/tb_idct2d_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/idct2d_sequencer.sv
// 8x8 2-D IDCT sequencer: loads 64 coefficients, drives a shared 1-D IDCT
// through 8 row passes and 8 column passes in place, then streams 64
// level-shifted, clamped pixels.
module idct2d_sequencer #(
  parameter int CW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_data,
  output logic [8*CW-1:0] idct_x,
  output logic            idct_valid,
  input  logic [8*CW-1:0] idct_y,
  input  logic            idct_rdy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            busy
);

  typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [CW-1:0] mem_q [64];
  logic [CW-1:0] mem_d [64];
  logic          in_ready_q, in_ready_d;
  logic          idct_valid_q, idct_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          busy_q, busy_d;

  assign in_ready   = in_ready_q;
  assign idct_valid = idct_valid_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;

  // Level shift by +128 at CW+1 bits so large magnitudes cannot wrap, then clamp.
  function automatic logic [7:0] sat_pix(input logic [CW-1:0] v);
    logic signed [CW:0] s;
    s = $signed({v[CW-1], v}) + $signed((CW+1)'(128));
    if (s < 0)                              sat_pix = 8'd0;
    else if (s > $signed((CW+1)'(255)))     sat_pix = 8'd255;
    else                                    sat_pix = s[7:0];
  endfunction

  // Feed the current row (ROW) or column (COL) of the buffer to the 1-D IDCT.
  always_comb begin
    idct_x = '0;
    for (int k = 0; k < 8; k++) begin
      if (state_q == COL) idct_x[k*CW +: CW] = mem_q[{3'(k), idx_q[2:0]}];
      else                idct_x[k*CW +: CW] = mem_q[{idx_q[2:0], 3'(k)}];
    end
  end

  // Next-state, buffer write-back and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    case (state_q)
      LOAD: if (in_valid && in_ready_q) begin
        mem_d[idx_q] = in_data;
        if (idx_q == 6'd63) begin idx_d = '0; state_d = ROW; end
        else idx_d = idx_q + 6'd1;
      end
      ROW: if (idct_rdy) begin
        for (int k = 0; k < 8; k++) mem_d[{idx_q[2:0], 3'(k)}] = idct_y[k*CW +: CW];
        if (idx_q[2:0] == 3'd7) begin idx_d = '0; state_d = COL; end
        else idx_d = idx_q + 6'd1;
      end
      COL: if (idct_rdy) begin
        for (int k = 0; k < 8; k++) mem_d[{3'(k), idx_q[2:0]}] = idct_y[k*CW +: CW];
        if (idx_q[2:0] == 3'd7) begin idx_d = '0; state_d = OUT; end
        else idx_d = idx_q + 6'd1;
      end
      OUT: if (out_valid_q && out_ready) begin
        if (idx_q == 6'd63) begin idx_d = '0; state_d = LOAD; end
        else idx_d = idx_q + 6'd1;
      end
      default: begin idx_d = '0; state_d = LOAD; end
    endcase
    in_ready_d   = (state_d == LOAD);
    idct_valid_d = (state_d == ROW) || (state_d == COL);
    out_valid_d  = (state_d == OUT);
    busy_d       = (state_d != LOAD);
    // Pixel is looked up from the post-update buffer so it is ready the
    // same cycle out_valid rises after the last column capture.
    out_data_d   = (state_d == OUT) ? sat_pix(mem_d[idx_d]) : 8'd0;
  end

  // State, counter and registered outputs; the buffer itself is not reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      in_ready_q   <= 1'b1;
      idct_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      in_ready_q   <= in_ready_d;
      idct_valid_q <= idct_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
    end
  end

  // Coefficient buffer storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 64; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: tb/tb_idct2d_sequencer.sv
// Self-checking bench for idct2d_sequencer with a behavioural 1-D IDCT stub
// (identity, optional +k position add, optional handshake stalls).
module tb_idct2d_sequencer;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CW-1:0]   in_data = '0;
  logic [8*CW-1:0] idct_x;
  logic            idct_valid;
  logic [8*CW-1:0] idct_y;
  logic            idct_rdy;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_data;
  logic            busy;

  idct2d_sequencer #(.CW(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .idct_x(idct_x), .idct_valid(idct_valid), .idct_y(idct_y), .idct_rdy(idct_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int q[$];
  int blk[64];
  int expv[64];
  logic add_pos  = 1'b0;
  logic stall_en = 1'b0;
  int item = 0;
  int wt   = 0;

  task automatic chk(input string tag, input logic [8*CW-1:0] got, input logic [8*CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // 1-D IDCT stub: y_k = x_k (+k when add_pos).
  always_comb begin
    for (int k = 0; k < 8; k++)
      idct_y[k*CW +: CW] = idct_x[k*CW +: CW] + (add_pos ? CW'(k) : CW'(0));
  end

  // Stall generator: every odd row/column item holds rdy low for 3 cycles.
  assign idct_rdy = !(stall_en && item[0] && (wt < 3));
  always @(posedge clk) begin
    if (!idct_valid) begin item <= 0; wt <= 0; end
    else if (idct_rdy) begin item <= item + 1; wt <= 0; end
    else wt <= wt + 1;
  end

  // idct_x must not move while the IDCT stalls.
  logic            pstall_x = 1'b0;
  logic [8*CW-1:0] px = '0;
  always @(negedge clk) begin
    if (stall_en && pstall_x && idct_valid) chk("idct_x_hold", idct_x, px);
    pstall_x = idct_valid && !idct_rdy && !reset;
    px = idct_x;
  end

  // Drive one block; expected pixels are queued as each coefficient is accepted.
  // Returns at the negedge after the final accept; keeps in_valid high with junk.
  task automatic send_block();
    for (int i = 0; i < 64; i++) begin
      int w;
      in_valid = 1'b1;
      in_data  = CW'(blk[i]);
      w = 0;
      while (!in_ready && w < 400) begin @(negedge clk); w++; end
      if (!in_ready) begin chk("in_timeout", 0, 1); return; end
      q.push_back(expv[i]);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = CW'(999);
  endtask

  task automatic recv_block(input bit pat, input int exp_lat);
    int got, cyc, lat, e;
    logic pst;
    logic [7:0] pd;
    got = 0; cyc = 0; lat = -1; pst = 1'b0; pd = '0;
    while (got < 64 && cyc < 3000) begin
      out_ready = pat ? ((cyc % 3) == 0) : 1'b1;
      if (cyc == 0) begin
        chk("busy_after_load", 32'(busy), 1);
        chk("in_ready_busy", 32'(in_ready), 0);
      end
      if (out_valid && lat < 0) begin
        lat = cyc + 1;
        chk("latency", lat, exp_lat);
        chk("busy_out", 32'(busy), 1);
      end
      if (pst) chk("out_hold", 32'(out_data), 32'(pd));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("q_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("pix", 32'(out_data), e);
        end
        got++;
      end
      pst = out_valid && !out_ready;
      pd  = out_data;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("pix_count", got, 64);
    chk("end_in_ready", 32'(in_ready), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_out_valid", 32'(out_valid), 0);
  endtask

  task automatic set_t1();
    for (int i = 0; i < 64; i++) begin blk[i] = i - 128; expv[i] = i; end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_idct_valid", 32'(idct_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);

    // T1 identity
    set_t1();
    send_block();
    recv_block(1'b0, 17);

    // T2 saturation
    for (int i = 0; i < 64; i++) begin blk[i] = 0; expv[i] = 128; end
    blk[0] = 500;  expv[0] = 255;
    blk[1] = -500; expv[1] = 0;
    blk[2] = 127;  expv[2] = 255;
    blk[3] = -129; expv[3] = 0;
    send_block();
    recv_block(1'b0, 17);

    // T3 transpose: row pass adds c, column pass adds r
    add_pos = 1'b1;
    for (int i = 0; i < 64; i++) begin
      blk[i]  = ((i * 53) % 400) - 200;
      expv[i] = sat8(blk[i] + 128 + (i / 8) + (i % 8));
    end
    send_block();
    recv_block(1'b0, 17);
    add_pos = 1'b0;

    // T4 IDCT stalls
    stall_en = 1'b1;
    set_t1();
    send_block();
    recv_block(1'b0, 41);
    stall_en = 1'b0;

    // T5 output backpressure
    set_t1();
    send_block();
    recv_block(1'b1, 17);

    // T6 reset during column pass (c=4), then reload
    set_t1();
    send_block();
    repeat (12) begin
      chk("t6_no_out", 32'(out_valid), 0);
      @(negedge clk);
    end
    chk("t6_in_col", 32'(idct_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_out_valid", 32'(out_valid), 0);
    send_block();
    recv_block(1'b0, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
